wb_decoder: RTL and testbench

Parametrised Wishbone B4 classic single-master, N-slave interconnect. It replaces the bus-sharing wiring between the CPU and its slaves (flash emulator, memory, control). It decodes each master cycle against per-slave address windows and routes strobe and return data to exactly one slave. Unmapped addresses and hung slaves are answered with a bus error.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_addr_decode.sv | 35 +++
 rtl/wb_decoder.sv | 184 ++++++++++++++++++
 tb/tb_wb_decoder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths, decoder limits, the decoder state type and a
// helper for sizing slave-index fields.
//
// Used by wb_addr_decode and wb_decoder (import wb_pkg::*).
package wb_pkg;

    localparam int unsigned WB_ADDR_W  = 32;
    localparam int unsigned WB_DATA_W  = 32;
    localparam int unsigned WB_SEL_W   = 4;
    localparam int unsigned MAX_SLAVES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ERROR = 2'd2
    } wb_dec_state_t;

    // Index width for n slaves; a single slave still needs a 1-bit field.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// wb_addr_decode: combinational address-window priority decoder.
//
// A window i matches when (adr - base_i) < size_i (unsigned), which also covers
// windows that end at the top of the address space. Where windows overlap the
// lowest slave index wins.
//
// Ports:
//   adr  in   WB_ADDR_W  byte address of the current request
//   hit  out  1          some window matches adr
//   idx  out  IDX_W      index of the lowest matching window (0 when no hit)
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter int unsigned                   NUM_SLAVES     = 3,
    parameter logic [NUM_SLAVES*32-1:0]      BASE_ADDRESSES = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
    parameter logic [NUM_SLAVES*32-1:0]      SIZES          = {32'h0000_1000, 32'h0000_4000, 32'h0020_0000},
    parameter int unsigned                   IDX_W          = idx_width(NUM_SLAVES)
) (
    input  logic [WB_ADDR_W-1:0] adr,
    output logic                 hit,
    output logic [IDX_W-1:0]     idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((adr - BASE_ADDRESSES[i*32 +: 32]) < SIZES[i*32 +: 32])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_decoder.sv
// wb_decoder: Wishbone B4 classic single-master, N-slave interconnect.
//
// Each master cycle is decoded (registered) against per-slave address windows;
// strobe, cycle and terminations are then routed to/from exactly one slave.
// Unmapped addresses get a one-cycle bus error. With WB_DECODER_TIMEOUT_EN
// defined, a slave that stalls for TIMEOUT_CYCLES BUSY cycles is abandoned and
// the master gets a bus error instead.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cyc_i, stb_i, we_i      master cycle, strobe, write enable
//   adr_i, sel_i, dat_i     master address, byte selects, write data
//   dat_o                   read data to master (0 outside BUSY)
//   ack_o, err_o, rty_o     master terminations
//   s_cyc_o, s_stb_o        per-slave cycle and strobe
//   s_we_o, s_adr_o,
//   s_sel_o, s_dat_o        broadcast copies of the master request
//   s_dat_i                 per-slave read data, slave i at [32i+31:32i]
//   s_ack_i, s_err_i,
//   s_rty_i                 per-slave terminations
//
// Build option: WB_DECODER_TIMEOUT_EN enables the stall timeout.
module wb_decoder
    import wb_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES     = 3,
    parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRESSES = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SIZES          = {32'h0000_1000, 32'h0000_4000, 32'h0020_0000},
    parameter int unsigned              TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cyc_i,
    input  logic                           stb_i,
    input  logic                           we_i,
    input  logic [WB_ADDR_W-1:0]           adr_i,
    input  logic [WB_SEL_W-1:0]            sel_i,
    input  logic [WB_DATA_W-1:0]           dat_i,
    output logic [WB_DATA_W-1:0]           dat_o,
    output logic                           ack_o,
    output logic                           err_o,
    output logic                           rty_o,
    output logic [NUM_SLAVES-1:0]          s_cyc_o,
    output logic [NUM_SLAVES-1:0]          s_stb_o,
    output logic                           s_we_o,
    output logic [WB_ADDR_W-1:0]           s_adr_o,
    output logic [WB_SEL_W-1:0]            s_sel_o,
    output logic [WB_DATA_W-1:0]           s_dat_o,
    input  logic [NUM_SLAVES*WB_DATA_W-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]          s_ack_i,
    input  logic [NUM_SLAVES-1:0]          s_err_i,
    input  logic [NUM_SLAVES-1:0]          s_rty_i
);

    localparam int unsigned IDX_W = idx_width(NUM_SLAVES);

    if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES) begin : g_bad_num_slaves
        $error("wb_decoder: NUM_SLAVES out of range 1..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_decoder: TIMEOUT_CYCLES out of range 1..65535");
    end

    wb_dec_state_t          state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   sel_ack, sel_err, sel_rty;
    logic [WB_DATA_W-1:0]   sel_dat;
    logic                   expired;

    wb_addr_decode #(
        .NUM_SLAVES     (NUM_SLAVES),
        .BASE_ADDRESSES (BASE_ADDRESSES),
        .SIZES          (SIZES),
        .IDX_W          (IDX_W)
    ) u_addr_decode (
        .adr (adr_i),
        .hit (hit),
        .idx (hit_idx)
    );

    assign s_we_o  = we_i;
    assign s_adr_o = adr_i;
    assign s_sel_o = sel_i;
    assign s_dat_o = dat_i;

    // Return-path mux for the latched slave.
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_rty = 1'b0;
        sel_dat = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ack = s_ack_i[i];
                sel_err = s_err_i[i];
                sel_rty = s_rty_i[i];
                sel_dat = s_dat_i[i*WB_DATA_W +: WB_DATA_W];
            end
        end
    end

`ifdef WB_DECODER_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Held at zero outside BUSY, so it is already clear on entry to BUSY and
    // equals (BUSY cycles elapsed - 1) during BUSY.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q == BUSY) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign expired = (state_q == BUSY) && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        s_cyc_o = '0;
        s_stb_o = '0;
        ack_o   = 1'b0;
        err_o   = 1'b0;
        rty_o   = 1'b0;
        dat_o   = '0;
        case (state_q)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    if (hit) begin
                        state_d = BUSY;
                        idx_d   = hit_idx;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            BUSY: begin
                for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        s_cyc_o[i] = cyc_i;
                        s_stb_o[i] = stb_i;
                    end
                end
                dat_o = sel_dat;
                // Only the highest-priority termination reaches the master.
                err_o = stb_i & sel_err;
                rty_o = stb_i & sel_rty & ~sel_err;
                ack_o = stb_i & sel_ack & ~sel_err & ~sel_rty;
                if (!cyc_i) begin
                    state_d = IDLE;
                end else if (stb_i && (sel_ack || sel_err || sel_rty)) begin
                    state_d = IDLE;
                end else if (expired) begin
                    state_d = ERROR;
                end
            end
            ERROR: begin
                err_o   = stb_i;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_decoder.sv
// tb_wb_decoder: randomized scoreboard bench for wb_decoder.
//
// A driver issues master cycles and pushes the expected termination (kind,
// data, arrival cycle) computed from a plain address-window model; a monitor
// on the falling edge pops and compares whenever the DUT terminates, and also
// polices which slave is strobed and the broadcast request fields.
module tb_wb_decoder;
    import wb_pkg::*;

    localparam int NS = 4;
    localparam int T  = 8;
    // Slave 3 overlaps slave 0 so the lowest-index rule is exercised.
    localparam logic [NS*32-1:0] BASES = {32'h1000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    localparam logic [NS*32-1:0] SZS   = {32'h1000_0000, 32'h0000_1000, 32'h0000_4000, 32'h0020_0000};
    localparam int K_ACK = 0;
    localparam int K_ERR = 1;
    localparam int K_RTY = 2;

    logic [31:0] m_base [NS] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h1000_0000};
    logic [31:0] m_size [NS] = '{32'h0020_0000, 32'h0000_4000, 32'h0000_1000, 32'h1000_0000};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0]       adr = '0, dat = '0;
    logic [3:0]        sel = '0;
    logic [31:0]       dat_o;
    logic              ack, err, rty;
    logic [NS-1:0]     s_cyc, s_stb;
    logic              s_we;
    logic [31:0]       s_adr, s_dat;
    logic [3:0]        s_sel;
    logic [NS*32-1:0]  s_dat_i;
    logic [NS-1:0]     s_ack_i, s_err_i, s_rty_i;

    wb_decoder #(
        .NUM_SLAVES     (NS),
        .BASE_ADDRESSES (BASES),
        .SIZES          (SZS),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .cyc_i   (cyc),
        .stb_i   (stb),
        .we_i    (we),
        .adr_i   (adr),
        .sel_i   (sel),
        .dat_i   (dat),
        .dat_o   (dat_o),
        .ack_o   (ack),
        .err_o   (err),
        .rty_o   (rty),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_we_o  (s_we),
        .s_adr_o (s_adr),
        .s_sel_o (s_sel),
        .s_dat_o (s_dat),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_rty_i (s_rty_i)
    );

    always #5 clk = ~clk;

    // ---------------- slave models ----------------
    logic [2:0]  cfg_term [NS];   // {err, rty, ack}
    int          cfg_wait [NS];
    logic [31:0] cfg_data [NS];
    int          wcnt     [NS];
    logic [NS-1:0] noise_ack = '0, noise_err = '0;

    initial begin
        for (int i = 0; i < NS; i++) begin
            cfg_term[i] = 3'b000;
            cfg_wait[i] = 0;
            cfg_data[i] = '0;
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NS; i++) begin
            if (rst || !s_stb[i]) wcnt[i] <= 0;
            else                  wcnt[i] <= wcnt[i] + 1;
        end
    end

    always_comb begin
        s_ack_i = '0;
        s_err_i = '0;
        s_rty_i = '0;
        s_dat_i = '0;
        for (int i = 0; i < NS; i++) begin
            s_ack_i[i] = (s_stb[i] && wcnt[i] >= cfg_wait[i] && cfg_term[i][0]) || noise_ack[i];
            s_rty_i[i] =  s_stb[i] && wcnt[i] >= cfg_wait[i] && cfg_term[i][1];
            s_err_i[i] = (s_stb[i] && wcnt[i] >= cfg_wait[i] && cfg_term[i][2]) || noise_err[i];
            s_dat_i[i*32 +: 32] = cfg_data[i];
        end
    end

    // ---------------- reference model ----------------
    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ({1'b0, a} >= {1'b0, m_base[i]} && {1'b0, a} < ({1'b0, m_base[i]} + {1'b0, m_size[i]}))
                return i;
        end
        return -1;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int          kind;
        logic [31:0] data;
        longint      at;
    } exp_t;

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc_cnt = 0;
    int     term_seen  = 0;
    int     stb_cycles = 0;
    int     cur_tgt    = -1;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc_cnt);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t          e;
        logic [NS-1:0] allowed;
        int            kind;
        if (!rst) begin
            allowed = '0;
            if (cur_tgt >= 0) allowed[cur_tgt] = 1'b1;
            check("strobe_target", 64'((s_stb | s_cyc) & ~allowed), 64'd0);
            if (s_stb != '0) begin
                stb_cycles++;
                check("broadcast_ctl", 64'({s_we, s_sel, s_adr}), 64'({we, sel, adr}));
                check("broadcast_dat", 64'(s_dat), 64'(dat));
            end
            if (ack || err || rty) begin
                term_seen++;
                check("term_onehot", 64'(int'(ack) + int'(err) + int'(rty)), 64'd1);
                kind = err ? K_ERR : (rty ? K_RTY : K_ACK);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_term: ack=%0b err=%0b rty=%0b, required none (cycle %0d)",
                             ack, err, rty, cyc_cnt);
                end else begin
                    e = sb.pop_front();
                    check("term_kind", 64'(kind), 64'(e.kind));
                    check("term_cycle", 64'(cyc_cnt), 64'(e.at));
                    check("term_data", 64'(dat_o), 64'(e.data));
                end
            end else if (cyc && s_stb == '0) begin
                check("dat_idle", 64'(dat_o), 64'd0);
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 of the cycle after termination
    // with the master idle, so a following call is back-to-back.
    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] sl,
                          input logic [31:0] d, input int waits, input logic [2:0] term,
                          input logic [31:0] sdata, input logic noisy);
        int   tgt;
        exp_t e;
        int   seen0, stb0, exp_stb;
        tgt = model_decode(a);
        for (int i = 0; i < NS; i++) begin
            cfg_data[i] = $urandom;
            cfg_term[i] = 3'b000;
            cfg_wait[i] = 0;
        end
        noise_ack = noisy ? NS'($urandom) : '0;
        noise_err = noisy ? NS'($urandom) : '0;
        e.kind  = K_ERR;
        e.data  = '0;
        e.at    = cyc_cnt + 1;
        exp_stb = 0;
        if (tgt >= 0) begin
            noise_ack[tgt] = 1'b0;
            noise_err[tgt] = 1'b0;
            cfg_data[tgt]  = sdata;
            cfg_wait[tgt]  = waits;
            cfg_term[tgt]  = term;
            if (term == 3'b000) begin
                e.at    = cyc_cnt + 1 + T;
                exp_stb = T;
            end else begin
                e.at    = cyc_cnt + 1 + waits;
                e.data  = sdata;
                exp_stb = waits + 1;
                e.kind  = term[2] ? K_ERR : (term[1] ? K_RTY : K_ACK);
            end
        end
        sb.push_back(e);
        seen0   = term_seen;
        stb0    = stb_cycles;
        cur_tgt = tgt;
        adr = a; we = w; sel = sl; dat = d;
        cyc = 1'b1; stb = 1'b1;
        for (int k = 0; k < 40 && term_seen == seen0; k++) @(posedge clk);
        check("term_arrived", 64'(term_seen != seen0), 64'd1);
        check("stb_cycles", 64'(stb_cycles - stb0), 64'(exp_stb));
        if (term_seen == seen0) sb.delete();
        #1;
        cyc = 1'b0; stb = 1'b0;
        cur_tgt   = -1;
        noise_ack = '0;
        noise_err = '0;
        adr = $urandom;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] a;
        int          s, pick, gap;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({dat_o, ack, err, rty, s_cyc, s_stb}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed: zero-wait read, waited write, unmapped, priorities, overlap.
        access(32'h1000_0010, 1'b0, 4'hF, 32'h0, 0, 3'b001, 32'hDEAD_BEEF, 1'b0);
        access(32'h2000_3FFC, 1'b1, 4'b0011, 32'hA5A5_0F0F, 3, 3'b001, 32'h1111_2222, 1'b0);
        access(32'h4000_0000, 1'b0, 4'hF, 32'h0, 0, 3'b001, 32'h0, 1'b0);
        access(32'h3000_0FFC, 1'b0, 4'hF, 32'h0, 1, 3'b111, 32'h3333_4444, 1'b0);
        access(32'h3000_0000, 1'b0, 4'hF, 32'h0, 0, 3'b011, 32'h5555_6666, 1'b0);
        access(32'h3000_1000, 1'b0, 4'hF, 32'h0, 0, 3'b001, 32'h0, 1'b1);
        access(32'h101F_FFFC, 1'b0, 4'hF, 32'h0, 0, 3'b001, 32'h7777_8888, 1'b1);
        access(32'h1020_0000, 1'b0, 4'hF, 32'h0, 2, 3'b001, 32'h9999_AAAA, 1'b1);
        access(32'h2000_0000, 1'b0, 4'hF, 32'h0, T - 1, 3'b001, 32'hCAFE_0001, 1'b1);
`ifdef WB_DECODER_TIMEOUT_EN
        access(32'h3000_0040, 1'b0, 4'hF, 32'h0, 0, 3'b000, 32'h1234_5678, 1'b0);
`endif

        // Abort: slave 0 stalls, slave 1 acks spuriously, master drops cyc.
        for (int i = 0; i < NS; i++) begin
            cfg_term[i] = 3'b000;
            cfg_wait[i] = 0;
        end
        noise_ack = 4'b0010;
        cur_tgt = 0;
        adr = 32'h1000_0100; we = 1'b0; sel = 4'hF;
        cyc = 1'b1; stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_stb_busy", 64'(s_stb), 64'(4'b0001));
        cyc = 1'b0; stb = 1'b0;
        #1;
        check("abort_stb_drop", 64'({s_cyc, s_stb}), 64'd0);
        check("abort_no_term", 64'({ack, err, rty}), 64'd0);
        cur_tgt   = -1;
        noise_ack = '0;
        @(posedge clk);
        #1;
        access(32'h1000_0200, 1'b0, 4'hF, 32'h0, 1, 3'b001, 32'h0BAD_F00D, 1'b0);

        // Reset during BUSY.
        cfg_term[1] = 3'b001;
        cfg_wait[1] = 6;
        cfg_data[1] = 32'hFEED_FACE;
        cur_tgt = 1;
        adr = 32'h2000_0100; cyc = 1'b1; stb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pre_busy", 64'(s_stb), 64'(4'b0010));
        rst = 1'b1;
        #1;
        check("rst_async_clear", 64'({dat_o, ack, err, rty, s_cyc, s_stb}), 64'd0);
        cyc = 1'b0; stb = 1'b0;
        cur_tgt = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        access(32'h2000_0104, 1'b0, 4'hF, 32'h0, 0, 3'b001, 32'h600D_0001, 1'b0);

        // Randomized traffic around window edges.
        for (int n = 0; n < 60; n++) begin
            s    = $urandom_range(0, NS - 1);
            pick = $urandom_range(0, 5);
            case (pick)
                0:       a = m_base[s];
                1:       a = m_base[s] + m_size[s] - 32'd1;
                2:       a = m_base[s] + ($urandom % m_size[s]);
                3:       a = m_base[s] + m_size[s];
                4:       a = m_base[s] - 32'd1;
                default: a = $urandom;
            endcase
            access(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 4),
                   3'($urandom_range(1, 7)), $urandom, 1'($urandom));
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
